// File: rtl/fetch_queue.sv
// RV32 fetch stage: issues word-aligned fetches under a credit limit and queues responses
// in order for decode. Redirects flush the queue and squash responses still in flight.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

  logic [CW-1:0]         count, inflight, drop;
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [DEPTH-1:0][31:0] q;
  logic [31:0]           fetch_pc, head_pc, tgt_pc;
  logic [CW:0]           occ;
  logic                  issue, push, pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  // Credit counts queued entries plus live in-flight fetches; a same-cycle pop is not credited.
  assign occ    = {1'b0, count} + {1'b0, inflight} - {1'b0, drop};
  assign issue  = rst_n && !redirect_valid && (occ < DEPTH_C);
  assign push   = imem_rvalid && (drop == '0) && !redirect_valid;
  assign pop    = id_valid && id_ready && !redirect_valid;
  assign tgt_pc = {redirect_pc[31:2], 2'b00};

  assign imem_req  = issue;
  assign imem_addr = fetch_pc;
  assign id_valid  = (count != '0);
  assign id_instr  = q[rd_ptr];
  assign id_pc     = head_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      q        <= '0;
      fetch_pc <= RESET_PC;
      head_pc  <= RESET_PC;
    end else if (redirect_valid) begin
      // Everything still outstanding belongs to the old path, including this cycle's response.
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inflight <= inflight - CW'(imem_rvalid);
      drop     <= inflight - CW'(imem_rvalid);
      fetch_pc <= tgt_pc;
      head_pc  <= tgt_pc;
    end else begin
      inflight <= inflight + CW'(issue) - CW'(imem_rvalid);
      count    <= count + CW'(push) - CW'(pop);
      if (imem_rvalid && drop != '0) drop <= drop - 1'b1;
      if (issue) fetch_pc <= fetch_pc + 32'd4;
      if (push) begin
        q[wr_ptr] <= imem_rdata;
        wr_ptr    <= nxt(wr_ptr);
      end
      if (pop) begin
        rd_ptr  <= nxt(rd_ptr);
        head_pc <= head_pc + 32'd4;
      end
    end
  end
endmodule
